// File: rtl/repair_seq_ctrl_pkg.sv
// repair_seq_ctrl_pkg: shared FSM encoding, spare-pointer layout and capacity limits
package repair_seq_ctrl_pkg;
    localparam int BANK_W    = 5;
    localparam int ROW_W     = 7;
    localparam int CNT_W     = 12;
    localparam int SEL_W     = 6;
    localparam int ADDR_W    = 10;
    localparam int ENTRY_W   = SEL_W + ADDR_W;
    localparam int MAX_FAULT = 3200;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, FAIL} state_e;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
    } spare_t;

    // Rows fill first; the last row of a bank rolls over into row 0 of the next bank.
    function automatic spare_t next_spare(spare_t s);
        spare_t n;
        n.row  = s.row + 7'd1;
        n.bank = (&s.row) ? s.bank + 5'd1 : s.bank;
        return n;
    endfunction
endpackage

// File: rtl/repair_seq_ctrl_if.sv
// repair_seq_ctrl_if: BIST fault-report and repair-log handshake bundle
interface repair_seq_ctrl_if;
    import repair_seq_ctrl_pkg::*;
    logic               START;
    logic               BIST_DONE;
    logic               BIST_FAIL_VALID;
    logic [SEL_W-1:0]   BIST_FAIL_SELECT;
    logic [ADDR_W-1:0]  BIST_FAIL_ADDR;
    logic               LOG_READY;
    logic               BIST_EN;
    logic               LOG_VALID;
    logic [ENTRY_W-1:0] LOG_ENTRY;
    logic [CNT_W-1:0]   LOG_SPARE;
    logic [CNT_W-1:0]   FAULT_COUNT;
    logic               BUSY;
    logic               REPAIR_EN;
    logic               OVERFLOW;

    modport master (
        output START, BIST_DONE, BIST_FAIL_VALID, BIST_FAIL_SELECT, BIST_FAIL_ADDR, LOG_READY,
        input  BIST_EN, LOG_VALID, LOG_ENTRY, LOG_SPARE, FAULT_COUNT, BUSY, REPAIR_EN, OVERFLOW
    );
    modport slave (
        input  START, BIST_DONE, BIST_FAIL_VALID, BIST_FAIL_SELECT, BIST_FAIL_ADDR, LOG_READY,
        output BIST_EN, LOG_VALID, LOG_ENTRY, LOG_SPARE, FAULT_COUNT, BUSY, REPAIR_EN, OVERFLOW
    );
endinterface

// File: rtl/repair_seq_ctrl_fault_fifo.sv
// fault_fifo: registered fault-report buffer; accepts a push into a full buffer when a pop coincides
module fault_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             last_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             wr, rd;
    assign wr      = push_i && (!full_o || pop_i);
    assign rd      = pop_i && !empty_o;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign last_o  = cnt_q == (AW+1)'(1);
    assign dout_o  = mem_q[rd_q];
    always_ff @(posedge CLK)
        if (wr && !clr_i) mem_q[wr_q] <= din_i;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr ? wr_q + AW'(1) : wr_q;
            rd_q  <= rd ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/repair_seq_ctrl.sv
// repair_seq_ctrl: sequences a BIST session, buffers fault reports and hands them to the repair log with spare allocation
module repair_seq_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_FAULT  = repair_seq_ctrl_pkg::MAX_FAULT
) (
    input logic              CLK,
    input logic              RSTN,
    repair_seq_ctrl_if.slave bus
);
    import repair_seq_ctrl_pkg::*;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    spare_t             spare_q, spare_d;
    logic               ovf_q, ovf_d, bist_en_q, busy_q, repair_en_q;
    logic               active, at_max, start, push, pop, fail_now, drained;
    logic               full, empty, last;
    logic [ENTRY_W-1:0] head;

    assign active   = state_q == RUN || state_q == DRAIN;
    assign at_max   = count_q == CNT_W'(MAX_FAULT);
    assign start    = bus.START && !active;
    assign push     = state_q == RUN && bus.BIST_FAIL_VALID;
    assign pop      = bus.LOG_VALID && bus.LOG_READY;
    // Capacity exhausted with work pending, or a report with nowhere to go.
    assign fail_now = active && ((at_max && !empty) || (push && full && !pop));
    assign drained  = empty || (pop && last);

    fault_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .clr_i   (start),
        .push_i  (push && !fail_now),
        .pop_i   (pop),
        .din_i   ({bus.BIST_FAIL_SELECT, bus.BIST_FAIL_ADDR}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .last_o  (last)
    );

    always_comb begin
        state_d = start ? RUN :
                  fail_now ? FAIL :
                  (state_q == RUN && bus.BIST_DONE) ? DRAIN :
                  (state_q == DRAIN && drained) ? DONE : state_q;
        count_d = start ? '0 : (pop && !at_max) ? count_q + CNT_W'(1) : count_q;
        spare_d = start ? '0 : pop ? next_spare(spare_q) : spare_q;
        ovf_d   = !start && (ovf_q || fail_now);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            count_q     <= '0;
            spare_q     <= '0;
            ovf_q       <= 1'b0;
            bist_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            repair_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            spare_q     <= spare_d;
            ovf_q       <= ovf_d;
            bist_en_q   <= state_d == RUN;
            busy_q      <= state_d == RUN || state_d == DRAIN;
            repair_en_q <= state_d == DONE && count_d != '0;
        end
    end

    assign bus.LOG_VALID   = active && !empty && !at_max;
    assign bus.LOG_ENTRY   = empty ? '0 : head;
    assign bus.LOG_SPARE   = spare_q;
    assign bus.FAULT_COUNT = count_q;
    assign bus.BIST_EN     = bist_en_q;
    assign bus.BUSY        = busy_q;
    assign bus.REPAIR_EN   = repair_en_q;
    assign bus.OVERFLOW    = ovf_q;
endmodule

// File: tb/tb_repair_seq_ctrl.sv
// tb_repair_seq_ctrl: randomized and directed sessions checked against a queue-based session model
module tb_repair_seq_ctrl;
    localparam int DEPTH = 4;
    localparam int MAXF  = 3200;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    repair_seq_ctrl_if bus ();
    repair_seq_ctrl #(.FIFO_DEPTH(DEPTH), .MAX_FAULT(MAXF)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] q[$];
    int          cnt;
    bit          ovf;
    string       ph;

    wire [44:0] obs = {bus.BIST_EN, bus.LOG_VALID, bus.LOG_ENTRY, bus.LOG_SPARE,
                       bus.FAULT_COUNT, bus.BUSY, bus.REPAIR_EN, bus.OVERFLOW};

    function automatic bit m_active();
        return ph == "RUN" || ph == "DRAIN";
    endfunction

    function automatic bit m_valid();
        return m_active() && q.size() > 0 && cnt < MAXF;
    endfunction

    function automatic logic [44:0] exp_vec();
        logic [15:0] e  = q.size() > 0 ? q[0] : 16'h0;
        logic [11:0] sp = {5'(cnt / 128), 7'(cnt % 128)};
        return {ph == "RUN", m_valid(), e, sp, 12'(cnt), m_active(), ph == "DONE" && cnt > 0, ovf};
    endfunction

    task automatic model_reset();
        q.delete();
        cnt = 0;
        ovf = 1'b0;
        ph  = "IDLE";
    endtask

    task automatic model_step(bit st, bit dn, bit fv, logic [15:0] f, bit rdy);
        bit pop  = m_valid() && rdy;
        bit push = ph == "RUN" && fv;
        if (st && !m_active()) begin
            q.delete();
            cnt = 0;
            ovf = 1'b0;
            ph  = "RUN";
            return;
        end
        if (!m_active()) return;
        if ((cnt == MAXF && q.size() > 0) || (push && q.size() == DEPTH && !pop)) begin
            ovf = 1'b1;
            ph  = "FAIL";
            return;
        end
        if (pop) begin
            void'(q.pop_front());
            cnt++;
        end
        if (push) q.push_back(f);
        if (ph == "RUN" && dn) ph = "DRAIN";
        else if (ph == "DRAIN" && q.size() == 0) ph = "DONE";
    endtask

    task automatic tick(bit st, bit dn, bit fv, logic [15:0] f, bit rdy);
        bus.START = st;
        bus.BIST_DONE = dn;
        bus.BIST_FAIL_VALID = fv;
        {bus.BIST_FAIL_SELECT, bus.BIST_FAIL_ADDR} = f;
        bus.LOG_READY = rdy;
        model_step(st, dn, fv, f, rdy);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (obs !== 45'h0) begin
            miscompares++;
            $display("FAIL reset_hold got=%h exp=%h", obs, 45'h0);
        end
        #2 RSTN = 1'b1;
        tick(0, 0, 1, 16'hbeef, 1);
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [15:0] f[3];
        tick(1, 0, 0, 0, 1);
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL basic_start got=%h exp=%h", obs, exp_vec());
        end
        for (int k = 0; k < 3; k++) begin
            f[k] = 16'($urandom);
            tick(0, 0, 1, f[k], 1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL basic_push%0d got=%h exp=%h", k, obs, exp_vec());
            end
            vectors++;
            if ({bus.LOG_VALID, bus.LOG_ENTRY, bus.LOG_SPARE} !== {1'b1, f[k], 12'(k)}) begin
                miscompares++;
                $display("FAIL basic_order%0d got=%h exp=%h", k,
                         {bus.LOG_VALID, bus.LOG_ENTRY, bus.LOG_SPARE}, {1'b1, f[k], 12'(k)});
            end
        end
        tick(0, 1, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL basic_done got=%h exp=%h", obs, exp_vec());
        end
        vectors++;
        if ({bus.FAULT_COUNT, bus.REPAIR_EN, bus.BUSY} !== {12'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_summary got=%h exp=%h", {bus.FAULT_COUNT, bus.REPAIR_EN, bus.BUSY}, {12'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_no_faults();
        tick(1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL nofault_c%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        vectors++;
        if ({bus.FAULT_COUNT, bus.REPAIR_EN, bus.BUSY} !== 14'h0) begin
            miscompares++;
            $display("FAIL nofault_summary got=%h exp=%h", {bus.FAULT_COUNT, bus.REPAIR_EN, bus.BUSY}, 14'h0);
        end
    endtask

    task automatic test_overflow();
        tick(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 1, 16'($urandom), 0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL ovf_push%0d got=%h exp=%h", k, obs, exp_vec());
            end
        end
        vectors++;
        if ({bus.OVERFLOW, bus.BIST_EN, bus.LOG_VALID, bus.BUSY} !== 4'b1000) begin
            miscompares++;
            $display("FAIL ovf_flags got=%b exp=%b", {bus.OVERFLOW, bus.BIST_EN, bus.LOG_VALID, bus.BUSY}, 4'b1000);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1, 16'($urandom), 1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL ovf_hold%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_spare_wrap();
        tick(1, 0, 0, 0, 1);
        for (int k = 0; k < 130; k++) begin
            tick(0, 0, 1, 16'($urandom), 1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL wrap_c%0d got=%h exp=%h", k, obs, exp_vec());
            end
            if (k == 128) begin
                vectors++;
                if (bus.LOG_SPARE !== 12'h080) begin
                    miscompares++;
                    $display("FAIL wrap_spare129 got=%h exp=%h", bus.LOG_SPARE, 12'h080);
                end
            end
        end
        tick(0, 1, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL wrap_done got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_stall_drain();
        logic [15:0] prev_entry;
        bit          prev_valid;
        bit          rdy;
        bit          reached = 1'b0;
        tick(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick(0, 0, 1, 16'($urandom), 0);
        prev_entry = bus.LOG_ENTRY;
        prev_valid = bus.LOG_VALID;
        for (int j = 0; j < 30 && !reached; j++) begin
            rdy = (j % 3) == 2;
            tick(0, j == 0, 0, 0, rdy);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL stall_c%0d got=%h exp=%h", j, obs, exp_vec());
            end
            if (prev_valid && !rdy) begin
                vectors++;
                if (bus.LOG_ENTRY !== prev_entry) begin
                    miscompares++;
                    $display("FAIL stall_stable%0d got=%h exp=%h", j, bus.LOG_ENTRY, prev_entry);
                end
            end
            prev_entry = bus.LOG_ENTRY;
            prev_valid = bus.LOG_VALID;
            reached = ph == "DONE";
        end
        vectors++;
        if (!reached || bus.REPAIR_EN !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_done got=%b exp=%b", bus.REPAIR_EN, 1'b1);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 4; s++) begin
            tick(1, 0, 0, 0, 1);
            for (int c = 0; c < 200; c++) begin
                tick(($urandom % 50) == 0, c == 150, bit'($urandom_range(0, 1)), 16'($urandom),
                     ($urandom % 3) != 0);
                vectors++;
                if (obs !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL random_s%0d_c%0d got=%h exp=%h", s, c, obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_saturation();
        tick(1, 0, 0, 0, 1);
        for (int k = 0; k < MAXF + 1; k++) begin
            tick(0, 0, 1, 16'($urandom), 1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL sat_c%0d got=%h exp=%h", k, obs, exp_vec());
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 0, 1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL sat_hold%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        vectors++;
        if ({bus.FAULT_COUNT, bus.OVERFLOW, bus.LOG_VALID} !== {12'd3200, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sat_summary got=%h exp=%h", {bus.FAULT_COUNT, bus.OVERFLOW, bus.LOG_VALID}, {12'd3200, 1'b1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_run();
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 16'($urandom), 0);
        tick(0, 0, 1, 16'($urandom), 0);
        #3 RSTN = 1'b0;
        #1;
        vectors++;
        if (obs !== 45'h0) begin
            miscompares++;
            $display("FAIL rstmid_async got=%h exp=%h", obs, 45'h0);
        end
        model_reset();
        #2 RSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 1);
            vectors++;
            if (obs !== exp_vec() || bus.LOG_VALID !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_release%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        bus.START = 1'b0;
        bus.BIST_DONE = 1'b0;
        bus.BIST_FAIL_VALID = 1'b0;
        bus.BIST_FAIL_SELECT = '0;
        bus.BIST_FAIL_ADDR = '0;
        bus.LOG_READY = 1'b0;
        test_reset();
        test_basic();
        test_no_faults();
        test_overflow();
        test_spare_wrap();
        test_stall_drain();
        test_random();
        test_saturation();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/repair_seq_ctrl.md
REPAIR_SEQ_CTRL -- requirements
Module: repair_seq_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, fault-report buffer entries (power of 2).
REQ-002 SHALL have parameter MAX_FAULT, default 3200 (128 rows x 25 spare banks), spare capacity.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RSTN  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  one-cycle pulse; begins a test/repair session.
REQ-006 BIST_DONE  input  1  BIST engine finished its march.
REQ-007 BIST_FAIL_VALID  input  1  fault report valid this cycle.
REQ-008 BIST_FAIL_SELECT  input  6  failing macro select.
REQ-009 BIST_FAIL_ADDR  input  10  failing word address.
REQ-010 LOG_READY  input  1  fault-table writer accepts an entry.
REQ-011 BIST_EN  output  1  enables BIST engine.
REQ-012 LOG_VALID  output  1  LOG_ENTRY/LOG_SPARE valid.
REQ-013 LOG_ENTRY  output  16  {SELECT, ADDR} of head fault.
REQ-014 LOG_SPARE  output  12  allocated spare: [11:7] bank, [6:0] row.
REQ-015 FAULT_COUNT  output  12  entries transferred this session.
REQ-016 BUSY  output  1  high in RUN or DRAIN.
REQ-017 REPAIR_EN  output  1  remap may be used (DONE and FAULT_COUNT>0).
REQ-018 OVERFLOW  output  1  sticky; buffer or spare capacity exceeded.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN, DONE, FAIL; BIST_EN SHALL be high only in RUN.
REQ-020 IDLE/DONE/FAIL + START SHALL enter RUN next cycle, clearing FIFO, FAULT_COUNT, spare pointer and OVERFLOW; START in RUN/DRAIN SHALL be ignored.
REQ-021 In RUN or in the cycle BIST_DONE is seen, BIST_FAIL_VALID SHALL push {SELECT,ADDR} into the FIFO; reports outside RUN SHALL be dropped.
REQ-022 A pushed entry SHALL appear on LOG_VALID/LOG_ENTRY no earlier than the next cycle (registered FIFO, 1-cycle latency when empty).
REQ-023 Transfer SHALL occur when LOG_VALID && LOG_READY: pop FIFO, FAULT_COUNT+1, spare pointer+1; LOG_ENTRY/LOG_SPARE SHALL be stable while LOG_VALID && !LOG_READY.
REQ-024 LOG_SPARE SHALL equal spare pointer; pointer increments row-first, wrapping row 127 -> row 0 of next bank.
REQ-025 Push and pop in the same cycle SHALL both succeed, including when FIFO is full.
REQ-026 Push into a full FIFO without simultaneous pop SHALL set OVERFLOW and go to FAIL; the report is discarded.
REQ-027 When FAULT_COUNT==MAX_FAULT and FIFO non-empty, LOG_VALID SHALL be held low, OVERFLOW set, state FAIL.
REQ-028 RUN + BIST_DONE SHALL go to DRAIN; DRAIN SHALL go to DONE on the cycle the FIFO becomes empty.
REQ-029 In FAIL, LOG_VALID and REPAIR_EN SHALL be low, FIFO contents held, until START.
REQ-030 FAULT_COUNT SHALL saturate at MAX_FAULT; counter widths SHALL be 12 bits, no wrap.

Reset
REQ-031 RSTN low SHALL asynchronously force IDLE, BIST_EN=0, LOG_VALID=0, LOG_ENTRY=0, LOG_SPARE=0, FAULT_COUNT=0, BUSY=0, REPAIR_EN=0, OVERFLOW=0, FIFO empty.
REQ-032 Reset mid-RUN SHALL discard all buffered reports; no transfer SHALL complete in the reset-release cycle.

Structure
REQ-033 FSM state encodings, MAX_FAULT, spare field widths (bank 5, row 7) SHALL live in a shared package used also by the repair-table block.
REQ-034 The report buffer SHALL be a sub-module fault_fifo (parameterised depth/width, full/empty flags).

Verification
REQ-035 START, 3 faults on consecutive RUN cycles, LOG_READY=1, then BIST_DONE -> entries in order, LOG_SPARE 0x000,0x001,0x002, FAULT_COUNT=3, DONE, REPAIR_EN=1.
REQ-036 START, BIST_DONE with no faults -> DONE, FAULT_COUNT=0, REPAIR_EN=0.
REQ-037 LOG_READY=0, 5 faults back-to-back (depth 4) -> 5th sets OVERFLOW, FAIL, BIST_EN=0.
REQ-038 Preload spare pointer path to 127 via 128 transfers -> 129th LOG_SPARE=0x080 (bank 1, row 0).
REQ-039 LOG_READY toggling 1-of-3 cycles with BIST_DONE while FIFO holds 3 -> DRAIN until empty, then DONE; LOG_ENTRY stable while stalled.
REQ-040 RSTN asserted mid-RUN with 2 buffered faults -> immediate IDLE, all outputs at reset values, no LOG_VALID after release.
